conv_window_generator: RTL
==========================

# conv_window_generator

Parametrised multi-channel K×K sliding-window generator for the CNN front end. It accepts a raster-order pixel stream carrying all channels in parallel, buffers K-1 lines per channel, and emits a complete K×K window per channel with a valid/ready handshake, window coordinates and a frame-done pulse. It sits between the pixel source and the convolution engine, replacing the fixed 3-channel, 3-tap column generator.

## Interface
- DATA_WIDTH, 8, bits per pixel per channel
- CHANNELS, 3, channels carried in parallel
- KERNEL, 3, window size K (≥2)
- IMG_W, 224, pixels per line
- IMG_H, 224, lines per frame

- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_data  in  CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  window valid
- out_ready  in  1  consumer accepts window
- out_window  out  CHANNELS*KERNEL*KERNEL*DATA_WIDTH  element (c,r,k) at offset ((c*K+r)*K+k)*DATA_WIDTH; r=0 top (oldest) row, k=0 leftmost (oldest) column
- out_row  out  clog2(IMG_H)  top-left row of window
- out_col  out  clog2(IMG_W)  top-left column of window
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Accept = in_valid && in_ready. in_ready = !rst && (!out_valid || out_ready).
- Per accept: column counter col advances 0..IMG_W-1 and wraps, incrementing row 0..IMG_H-1, which wraps to 0 (next frame). Line buffers and the window register shift only on accept.
- Window emitted for the accepted pixel at (row,col) iff row ≥ K-1 and col ≥ K-1 ("valid" convolution, no padding). It contains that pixel at (r=K-1, k=K-1). Window count per frame: (IMG_H-K+1)*(IMG_W-K+1).
- out_row = row-(K-1), out_col = col-(K-1).
- Output register: loaded on an emitting accept; out_valid stays high and out_window/out_row/out_col stay stable until out_ready. A simultaneous out_ready and new emitting accept reloads the register with out_valid held at 1.
- Accepting a non-emitting pixel while the consumer takes a window drops out_valid to 0.
- Line buffer contents are never reset or flushed. Stale data from a previous frame or from before reset is never emitted, because emission is gated by the row/col counters.
- Reset mid-frame: counters to 0, out_valid 0, frame_done 0. The next accepted pixel is (0,0).

## Timing
- Reset values: out_valid 0, out_window 0, out_row 0, out_col 0, frame_done 0. in_ready is 0 while rst is high.
- Latency: out_valid rises one cycle after the accept of the completing pixel.
- Throughput: one pixel per cycle with no backpressure.
- frame_done: registered pulse, exactly one cycle, the cycle after (IMG_H-1, IMG_W-1) is accepted. Without the stride feature it coincides with the rising out_valid of the last window. It is independent of out_ready.
- Gaps on in_valid freeze all state. No data is lost under any in_valid/out_ready pattern.

## Configuration
- CONV_WIN_STRIDE2_EN defined: a window is emitted only when out_row and out_col are both even. Per-frame window count = ceil((IMG_H-K+1)/2)*ceil((IMG_W-K+1)/2). The handshake is unchanged.
- CONV_WIN_STRIDE2_EN undefined: stride 1, every valid position is emitted.

## Structure
- Package conv_win_pkg holds the window offset function (c,r,k)→bit offset and localparams for counter widths and window count, shared with the convolution engine.
- Sub-module conv_line_buffer: one per channel, K-1 cascaded lines of depth IMG_W with shift enable, exposing the K-1 delayed taps. The top level holds the counters, the K×K window shift register, the output register and the handshake.

## Test plan
Common setup: CHANNELS=2, KERNEL=3, IMG_W=5, IMG_H=4, DATA_WIDTH=8; pixel ch0 = row*16+col, ch1 = ch0+0x80.
- Full frame, out_ready=1 -> 6 windows. First window rises the cycle after (2,2) is accepted, with out_row/out_col 0/0, ch0 row0 = 00,01,02, row2 = 20,21,22. Last window is (1,2) with ch1 (2,2)=0xB4. frame_done pulses once, with the last window.
- out_ready=0 for 5 cycles at the first window -> in_ready 0, window held stable, no pixel lost. The remaining 5 windows are correct.
- Random in_valid gaps (50%) -> the window sequence is identical to the first scenario.
- rst for 1 cycle after 7 pixels, then a full frame -> exactly 6 windows, first at (0,0) with the correct contents.
- Two back-to-back frames with a different pixel offset (+1) in frame 2 -> 12 windows. No frame-1 data appears in frame-2 windows, and two frame_done pulses.
- CONV_WIN_STRIDE2_EN defined, full frame -> 2 windows at (0,0) and (0,2). frame_done occurs the cycle after (3,4) is accepted.

Source files
------------

// File: rtl/conv_win_pkg.sv
// conv_win_pkg: shared definitions for the K x K window generator and the
// convolution engine that consumes its windows.
//   - cnt_width   : counter width for a 0..n-1 counter (at least 1 bit)
//   - win_offset  : bit offset of element (c,r,k) in a packed window
//   - win_count   : windows emitted per frame (honours CONV_WIN_STRIDE2_EN)
//   - DEF_*       : default geometry and derived widths/counts
package conv_win_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_CHANNELS   = 3;
  localparam int unsigned DEF_KERNEL     = 3;
  localparam int unsigned DEF_IMG_W      = 224;
  localparam int unsigned DEF_IMG_H      = 224;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // r=0 is the top (oldest) row, k=0 the leftmost (oldest) column
  function automatic int unsigned win_offset(input int unsigned c, input int unsigned r,
                                             input int unsigned k, input int unsigned kernel,
                                             input int unsigned data_width);
    return ((c * kernel + r) * kernel + k) * data_width;
  endfunction

  function automatic int unsigned win_count(input int unsigned img_h, input int unsigned img_w,
                                            input int unsigned kernel);
`ifdef CONV_WIN_STRIDE2_EN
    return ((img_h - kernel + 2) / 2) * ((img_w - kernel + 2) / 2);
`else
    return (img_h - kernel + 1) * (img_w - kernel + 1);
`endif
  endfunction

  localparam int unsigned DEF_ROW_W     = cnt_width(DEF_IMG_H);
  localparam int unsigned DEF_COL_W     = cnt_width(DEF_IMG_W);
  localparam int unsigned DEF_WIN_COUNT = win_count(DEF_IMG_H, DEF_IMG_W, DEF_KERNEL);

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: LINES cascaded shift lines of DEPTH pixels for one channel.
// Ports:
//   clk   clock
//   en    shift enable (one pixel accepted)
//   din   incoming pixel
//   taps  tap l (bits [l*DATA_WIDTH +: DATA_WIDTH]) = pixel accepted (l+1)*DEPTH shifts ago
// Contents are deliberately not reset; the consumer gates stale data by position.
module conv_line_buffer
  import conv_win_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_IMG_W,
  parameter int unsigned LINES      = DEF_KERNEL - 1
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic [LINES*DATA_WIDTH-1:0] taps
);

  logic [DATA_WIDTH-1:0] mem [LINES][DEPTH];

  // Shift chain: each line's tail feeds the head of the next
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0][0] <= din;
      for (int unsigned l = 1; l < LINES; l++) begin
        mem[l][0] <= mem[l-1][DEPTH-1];
      end
      for (int unsigned l = 0; l < LINES; l++) begin
        for (int unsigned i = 1; i < DEPTH; i++) begin
          mem[l][i] <= mem[l][i-1];
        end
      end
    end
  end

  always_comb begin
    taps = '0;
    for (int unsigned l = 0; l < LINES; l++) begin
      taps[l*DATA_WIDTH +: DATA_WIDTH] = mem[l][DEPTH-1];
    end
  end

endmodule

// File: rtl/conv_window_generator.sv
// conv_window_generator: multi-channel K x K sliding-window generator.
// Optional feature: define CONV_WIN_STRIDE2_EN to emit only windows whose
// top-left row and column are both even (stride 2).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/in_ready/in_data    raster pixel stream, all channels in parallel
//   out_valid/out_ready          window handshake
//   out_window     element (c,r,k) at win_offset(c,r,k)
//   out_row/out_col              top-left coordinate of the window
//   frame_done     one-cycle pulse after the last pixel of a frame is accepted
module conv_window_generator
  import conv_win_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CHANNELS   = DEF_CHANNELS,
  parameter int unsigned KERNEL     = DEF_KERNEL,
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]               in_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [CHANNELS*KERNEL*KERNEL*DATA_WIDTH-1:0] out_window,
  output logic [cnt_width(IMG_H)-1:0]                  out_row,
  output logic [cnt_width(IMG_W)-1:0]                  out_col,
  output logic                                         frame_done
);

  localparam int unsigned ROW_W = cnt_width(IMG_H);
  localparam int unsigned COL_W = cnt_width(IMG_W);
  localparam int unsigned LINES = KERNEL - 1;
  localparam int unsigned WIN_W = CHANNELS * KERNEL * KERNEL * DATA_WIDTH;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row_rel;
  logic [COL_W-1:0] col_rel;
  logic             accept;
  logic             emit;
  logic             row_ok;
  logic             col_ok;
  logic             last_row;
  logic             last_col;

  logic [LINES*DATA_WIDTH-1:0] taps [CHANNELS];
  logic [DATA_WIDTH-1:0]       win_q [CHANNELS][KERNEL][KERNEL];
  logic [DATA_WIDTH-1:0]       win_d [CHANNELS][KERNEL][KERNEL];
  logic [WIN_W-1:0]            win_flat;

  // Output register frees up either when empty or when drained this cycle
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign last_row = (row == ROW_W'(IMG_H - 1));
  assign last_col = (col == COL_W'(IMG_W - 1));
  assign row_ok   = (row >= ROW_W'(KERNEL - 1));
  assign col_ok   = (col >= COL_W'(KERNEL - 1));
  assign row_rel  = row - ROW_W'(KERNEL - 1);
  assign col_rel  = col - COL_W'(KERNEL - 1);

`ifdef CONV_WIN_STRIDE2_EN
  assign emit = row_ok && col_ok && !row_rel[0] && !col_rel[0];
`else
  assign emit = row_ok && col_ok;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lb
    conv_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_W),
      .LINES      (LINES)
    ) u_lb (
      .clk  (clk),
      .en   (accept),
      .din  (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .taps (taps[c])
    );
  end

  // Next window: shift left one column, new rightmost column from the taps
  // (oldest line at the top) and the incoming pixel at the bottom.
  always_comb begin
    win_d    = win_q;
    win_flat = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned r = 0; r < KERNEL; r++) begin
        for (int unsigned k = 0; k < KERNEL - 1; k++) begin
          win_d[c][r][k] = win_q[c][r][k+1];
        end
      end
      for (int unsigned r = 0; r < KERNEL - 1; r++) begin
        win_d[c][r][KERNEL-1] = taps[c][(KERNEL-2-r)*DATA_WIDTH +: DATA_WIDTH];
      end
      win_d[c][KERNEL-1][KERNEL-1] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
      for (int unsigned r = 0; r < KERNEL; r++) begin
        for (int unsigned k = 0; k < KERNEL; k++) begin
          win_flat[win_offset(c, r, k, KERNEL, DATA_WIDTH) +: DATA_WIDTH] = win_d[c][r][k];
        end
      end
    end
  end

  // Window shift register; not reset, emission is gated by position
  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_d;
    end
  end

  // Counters, output register and frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      out_valid  <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_row && last_col;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (accept && emit) begin
        out_valid  <= 1'b1;
        out_window <= win_flat;
        out_row    <= row_rel;
        out_col    <= col_rel;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
